// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the multi-port integer register file.
package cv32e40x_pkg;

    typedef logic [4:0]  rf_addr_t;
    typedef logic [31:0] rf_data_t;

    localparam int RF_DEFAULT_NUM_WRITE_PORTS = 1;
    localparam int RF_NUM_WORDS_I             = 32;
    localparam int RF_NUM_WORDS_E             = 16;

    // x0 and addresses beyond the configured depth are never stored, tracked or bypassed
    function automatic logic rf_addr_legal(rf_addr_t addr, int num_words);
        return (addr != '0) && (int'(addr) < num_words);
    endfunction

endpackage

// File: rtl/cv32e40x_register_file_mp_if.sv
// Decode/writeback side bundle of the multi-port register file.
interface cv32e40x_register_file_mp_if
    import cv32e40x_pkg::*;
#(
    parameter int NUM_RPORTS = 2,
    parameter int NUM_WPORTS = RF_DEFAULT_NUM_WRITE_PORTS
) ();

    rf_addr_t [NUM_RPORTS-1:0] raddr_i;
    rf_data_t [NUM_RPORTS-1:0] rdata_o;
    logic     [NUM_RPORTS-1:0] rbusy_o;
    logic     [NUM_RPORTS-1:0] rperr_o;
    rf_addr_t [NUM_WPORTS-1:0] waddr_i;
    rf_data_t [NUM_WPORTS-1:0] wdata_i;
    logic     [NUM_WPORTS-1:0] we_i;
    logic                      issue_valid_i;
    rf_addr_t                  issue_addr_i;

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, issue_valid_i, issue_addr_i,
        output rdata_o, rbusy_o, rperr_o
    );

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, issue_valid_i, issue_addr_i,
        input  rdata_o, rbusy_o, rperr_o
    );

endinterface

// File: rtl/cv32e40x_rf_scoreboard.sv
// Per-register busy bits for writes still outstanding; issue sets, writeback clears.
module cv32e40x_rf_scoreboard
    import cv32e40x_pkg::*;
#(
    parameter int NUM_WORDS  = RF_NUM_WORDS_I,
    parameter int NUM_WPORTS = RF_DEFAULT_NUM_WRITE_PORTS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  rf_addr_t [NUM_WPORTS-1:0] clr_addr_i,
    input  logic     [NUM_WPORTS-1:0] clr_en_i,
    input  logic                      set_valid_i,
    input  rf_addr_t                  set_addr_i,
    output logic     [NUM_WORDS-1:1]  busy_o
);

    logic [NUM_WORDS-1:1] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_WORDS; r++) begin
            for (int k = 0; k < NUM_WPORTS; k++) begin
                if (clr_en_i[k] && (clr_addr_i[k] == rf_addr_t'(r))) busy_d[r] = 1'b0;
            end
            // a fresh issue supersedes a write completing to the same register
            if (set_valid_i && (set_addr_i == rf_addr_t'(r))) busy_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/cv32e40x_register_file_mp.sv
// Multi-port integer register file with optional bypass, busy scoreboard and
// per-word even parity (enabled by defining CV32E40X_RF_PARITY_EN).
module cv32e40x_register_file_mp
    import cv32e40x_pkg::*;
#(
    parameter int REGFILE_NUM_READ_PORTS  = 2,
    parameter int REGFILE_NUM_WRITE_PORTS = RF_DEFAULT_NUM_WRITE_PORTS,
    parameter int REGFILE_NUM_WORDS       = RF_NUM_WORDS_I,
    parameter bit BYPASS                  = 1'b0
) (
    input logic                        clk,
    input logic                        rst_n,
    cv32e40x_register_file_mp_if.slave rf_if
);

    localparam int R  = REGFILE_NUM_READ_PORTS;
    localparam int W  = REGFILE_NUM_WRITE_PORTS;
    localparam int NW = REGFILE_NUM_WORDS;

    rf_data_t         mem_q [1:NW-1];
    rf_data_t         mem_d [1:NW-1];
    logic [NW-1:1]    busy;
    rf_data_t [R-1:0] rd_data;
    rf_data_t [R-1:0] byp_data;
    logic [R-1:0]     rd_busy;
    logic [R-1:0]     byp_hit;

    // ascending port order lets the highest-index writer win
    always_comb begin
        for (int r = 1; r < NW; r++) begin
            mem_d[r] = mem_q[r];
            for (int k = 0; k < W; k++) begin
                if (rf_if.we_i[k] && (rf_if.waddr_i[k] == rf_addr_t'(r))) mem_d[r] = rf_if.wdata_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 1; r < NW; r++) begin
            if (!rst_n) mem_q[r] <= '0;
            else        mem_q[r] <= mem_d[r];
        end
    end

    cv32e40x_rf_scoreboard #(
        .NUM_WORDS  (NW),
        .NUM_WPORTS (W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_addr_i  (rf_if.waddr_i),
        .clr_en_i    (rf_if.we_i),
        .set_valid_i (rf_if.issue_valid_i),
        .set_addr_i  (rf_if.issue_addr_i),
        .busy_o      (busy)
    );

`ifdef CV32E40X_RF_PARITY_EN
    logic [NW-1:1] par_q, par_d;
    logic [R-1:0]  rd_par;

    // parity only changes on a write, so a corrupted word stays detectable
    always_comb begin
        par_d = par_q;
        for (int r = 1; r < NW; r++) begin
            for (int k = 0; k < W; k++) begin
                if (rf_if.we_i[k] && (rf_if.waddr_i[k] == rf_addr_t'(r))) par_d[r] = ^rf_if.wdata_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= '0;
        else        par_q <= par_d;
    end
`endif

    always_comb begin
        for (int i = 0; i < R; i++) begin
            rd_data[i]  = '0;
            rd_busy[i]  = 1'b0;
            byp_hit[i]  = 1'b0;
            byp_data[i] = '0;
`ifdef CV32E40X_RF_PARITY_EN
            rd_par[i]   = 1'b0;
`endif
            for (int r = 1; r < NW; r++) begin
                if (rf_if.raddr_i[i] == rf_addr_t'(r)) begin
                    rd_data[i] = mem_q[r];
                    rd_busy[i] = busy[r];
`ifdef CV32E40X_RF_PARITY_EN
                    rd_par[i]  = par_q[r];
`endif
                end
            end
            if (BYPASS) begin
                for (int k = 0; k < W; k++) begin
                    if (rf_if.we_i[k] && rf_addr_legal(rf_if.waddr_i[k], NW) &&
                        (rf_if.waddr_i[k] == rf_if.raddr_i[i])) begin
                        byp_hit[i]  = 1'b1;
                        byp_data[i] = rf_if.wdata_i[k];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < R; i++) begin
            rf_if.rdata_o[i] = !rst_n ? '0 : (byp_hit[i] ? byp_data[i] : rd_data[i]);
            rf_if.rbusy_o[i] = rst_n && rd_busy[i] && !byp_hit[i];
`ifdef CV32E40X_RF_PARITY_EN
            rf_if.rperr_o[i] = rst_n && !byp_hit[i] && ((^rd_data[i]) != rd_par[i]);
`else
            rf_if.rperr_o[i] = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_cv32e40x_register_file_mp.sv
// Two register files (RV32I with bypass, RV32E without) driven by one stimulus
// stream and compared against an array model of the architectural state.
module tb_cv32e40x_register_file_mp;
    import cv32e40x_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cv32e40x_register_file_mp_if #(.NUM_RPORTS(2), .NUM_WPORTS(2)) if_a ();
    cv32e40x_register_file_mp_if #(.NUM_RPORTS(2), .NUM_WPORTS(2)) if_b ();

    cv32e40x_register_file_mp #(
        .REGFILE_NUM_READ_PORTS(2), .REGFILE_NUM_WRITE_PORTS(2),
        .REGFILE_NUM_WORDS(32), .BYPASS(1'b1)
    ) dut_a (.clk(clk), .rst_n(rst_n), .rf_if(if_a));

    cv32e40x_register_file_mp #(
        .REGFILE_NUM_READ_PORTS(2), .REGFILE_NUM_WRITE_PORTS(2),
        .REGFILE_NUM_WORDS(16), .BYPASS(1'b0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .rf_if(if_b));

    int n_chk = 0;
    int n_err = 0;

    // architectural model: [0] = RV32I bypassing file, [1] = RV32E plain file
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    int          m_nw   [2] = '{32, 16};
    bit          m_byp  [2] = '{1'b1, 1'b0};

    logic [4:0]  s_ra [2];
    logic [4:0]  s_wa [2];
    logic [31:0] s_wd [2];
    bit          s_we [2];
    bit          s_iv;
    logic [4:0]  s_ia;

`ifdef CV32E40X_RF_PARITY_EN
    logic [31:1] pq;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(int d, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < m_nw[d]);
    endfunction

    task automatic idle();
        s_we = '{1'b0, 1'b0};
        s_iv = 1'b0;
    endtask

    task automatic present();
        for (int k = 0; k < 2; k++) begin
            if_a.raddr_i[k] = s_ra[k];  if_b.raddr_i[k] = s_ra[k];
            if_a.waddr_i[k] = s_wa[k];  if_b.waddr_i[k] = s_wa[k];
            if_a.wdata_i[k] = s_wd[k];  if_b.wdata_i[k] = s_wd[k];
            if_a.we_i[k]    = s_we[k];  if_b.we_i[k]    = s_we[k];
        end
        if_a.issue_valid_i = s_iv;  if_b.issue_valid_i = s_iv;
        if_a.issue_addr_i  = s_ia;  if_b.issue_addr_i  = s_ia;
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                logic [31:0] e_data;
                bit          e_busy;
                logic [31:0] o_data;
                logic        o_busy, o_perr;
                e_data = legal(d, s_ra[i]) ? m_mem[d][s_ra[i]] : 32'h0;
                e_busy = legal(d, s_ra[i]) ? m_busy[d][s_ra[i]] : 1'b0;
                if (m_byp[d]) begin
                    for (int k = 0; k < 2; k++) begin
                        if (s_we[k] && legal(d, s_wa[k]) && s_wa[k] == s_ra[i]) begin
                            e_data = s_wd[k];
                            e_busy = 1'b0;
                        end
                    end
                end
                if (!rst_n) begin
                    e_data = 32'h0;
                    e_busy = 1'b0;
                end
                o_data = (d == 0) ? if_a.rdata_o[i] : if_b.rdata_o[i];
                o_busy = (d == 0) ? if_a.rbusy_o[i] : if_b.rbusy_o[i];
                o_perr = (d == 0) ? if_a.rperr_o[i] : if_b.rperr_o[i];
                chk($sformatf("rdata_%s%0d_x%0d", d ? "b" : "a", i, s_ra[i]), o_data, e_data);
                chk($sformatf("rbusy_%s%0d_x%0d", d ? "b" : "a", i, s_ra[i]), {31'h0, o_busy}, {31'h0, e_busy});
                chk($sformatf("rperr_%s%0d_x%0d", d ? "b" : "a", i, s_ra[i]), {31'h0, o_perr}, 32'h0);
            end
        end
    endtask

    task automatic commit();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) begin
                    m_mem[d][r]  = 32'h0;
                    m_busy[d][r] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (s_we[k] && legal(d, s_wa[k])) begin
                        m_mem[d][s_wa[k]]  = s_wd[k];
                        m_busy[d][s_wa[k]] = 1'b0;
                    end
                end
                if (s_iv && legal(d, s_ia)) m_busy[d][s_ia] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic step();
        present();
        commit();
    endtask

    initial begin
        rst_n = 1'b0;
        s_ra = '{5'd1, 5'd2};
        s_wa = '{5'd3, 5'd4};
        s_wd = '{32'h1234, 32'h5678};
        s_ia = 5'd6;
        s_we = '{1'b1, 1'b1};
        s_iv = 1'b1;
        step();
        step();

        rst_n = 1'b1;
        idle();
        for (int i = 1; i < 32; i += 2) begin
            s_ra[0] = 5'(i);
            s_ra[1] = 5'(i + 1);
            step();
        end

        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd5; s_wd[0] = 32'hDEADBEEF; s_ra = '{5'd5, 5'd5};
        step();
        idle(); present();
        chk("x5_a_port0", if_a.rdata_o[0], 32'hDEADBEEF);
        chk("x5_b_port1", if_b.rdata_o[1], 32'hDEADBEEF);
        commit();

        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd0; s_wd[0] = 32'h1; s_ra = '{5'd0, 5'd0};
        step();
        idle(); present();
        chk("x0_reads_zero", if_a.rdata_o[0], 32'h0);
        commit();

        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd7; s_wd[0] = 32'h33;
        step();
        idle(); s_we = '{1'b1, 1'b1}; s_wa = '{5'd7, 5'd7}; s_wd = '{32'h11, 32'h22}; s_ra = '{5'd7, 5'd7};
        present();
        chk("x7_bypass_hi_port", if_a.rdata_o[0], 32'h22);
        chk("x7_nobypass_old", if_b.rdata_o[0], 32'h33);
        commit();
        idle(); present();
        chk("x7_hi_port_wins", if_b.rdata_o[1], 32'h22);
        commit();

        idle(); s_iv = 1'b1; s_ia = 5'd9; s_ra = '{5'd9, 5'd9};
        step();
        idle(); present();
        chk("x9_busy", {31'h0, if_b.rbusy_o[0]}, 32'h1);
        commit();
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd9; s_wd[0] = 32'h99; s_iv = 1'b1; s_ia = 5'd9;
        step();
        idle(); s_we[1] = 1'b1; s_wa[1] = 5'd9; s_wd[1] = 32'h9A;
        present();
        chk("x9_set_beats_clear", {31'h0, if_b.rbusy_o[0]}, 32'h1);
        chk("x9_bypass_masks_busy", {31'h0, if_a.rbusy_o[0]}, 32'h0);
        commit();
        idle(); present();
        chk("x9_busy_cleared", {31'h0, if_b.rbusy_o[0]}, 32'h0);
        commit();

        idle(); s_we = '{1'b1, 1'b1}; s_wa = '{5'd20, 5'd15}; s_wd = '{32'h5, 32'h15};
        s_iv = 1'b1; s_ia = 5'd20;
        step();
        idle(); s_ra = '{5'd20, 5'd15};
        present();
        chk("x20_dropped_e", if_b.rdata_o[0], 32'h0);
        chk("x20_not_busy_e", {31'h0, if_b.rbusy_o[0]}, 32'h0);
        chk("x20_stored_i", if_a.rdata_o[0], 32'h5);
        chk("x15_stored_e", if_b.rdata_o[1], 32'h15);
        commit();

        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < 2; k++) begin
                s_ra[k] = 5'($urandom_range(0, 31));
                s_wa[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                s_wd[k] = $urandom;
                s_we[k] = ($urandom_range(0, 2) != 0);
            end
            s_iv = ($urandom_range(0, 2) == 0);
            s_ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step();
        end

`ifdef CV32E40X_RF_PARITY_EN
        rst_n = 1'b1;
        idle(); s_we[0] = 1'b1; s_wa[0] = 5'd3; s_wd[0] = 32'h1;
        step();
        idle(); s_ra = '{5'd3, 5'd3};
        present();
        pq = dut_a.par_q;
        pq[3] = ~pq[3];
        force dut_a.par_q = pq;
        #1;
        chk("x3_parity_flip", {31'h0, if_a.rperr_o[0]}, 32'h1);
        release dut_a.par_q;
        commit();
        rst_n = 1'b0; idle();
        step();
        rst_n = 1'b1; s_ra = '{5'd3, 5'd3};
        present();
        chk("x3_after_reset", if_a.rdata_o[0], 32'h0);
        chk("x3_perr_after_reset", {31'h0, if_a.rperr_o[0]}, 32'h0);
        commit();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
